// File: rtl/aggregator_mac.sv
`default_nettype none
// =============================================================================
// aggregator_mac : per-subgraph alpha x WH multiply-accumulate with scaled,
//                  saturated feature-vector output over valid/ready.
// Revision       : 1.0
// =============================================================================
module aggregator_mac #(
    parameter int WH_DATA_WIDTH     = 12,
    parameter int ALPHA_DATA_WIDTH  = 32,
    parameter int NEW_FEATURE_WIDTH = 32,
    parameter int NUM_FEATURE_OUT   = 16,
    parameter int MAX_NODES         = 168,
    parameter int NUM_SUBGRAPHS     = 2708,
    parameter int OUT_SHIFT         = 16,
    localparam int NUM_NODE_WIDTH   = $clog2(MAX_NODES),
    localparam int ACC_W            = WH_DATA_WIDTH + ALPHA_DATA_WIDTH + 1 + NUM_NODE_WIDTH
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic [MAX_NODES*ALPHA_DATA_WIDTH-1:0]          alpha,
    input  logic [NUM_NODE_WIDTH-1:0]                      num_nodes,
    input  logic                                           alpha_vld,
    output logic                                           alpha_rdy,
    input  logic [NUM_FEATURE_OUT*WH_DATA_WIDTH-1:0]       wh,
    input  logic                                           wh_vld,
    output logic                                           wh_rdy,
    output logic [NUM_FEATURE_OUT*NEW_FEATURE_WIDTH-1:0]   new_feat,
    output logic                                           new_feat_vld,
    input  logic                                           new_feat_rdy,
    output logic                                           aggr_done
);

    localparam int SG_W = $clog2(NUM_SUBGRAPHS + 1);
    localparam logic [NUM_NODE_WIDTH-1:0] MAX_N = NUM_NODE_WIDTH'(MAX_NODES);
    localparam logic signed [ACC_W-1:0] SAT_HI =
        {{(ACC_W-NEW_FEATURE_WIDTH+1){1'b0}}, {(NEW_FEATURE_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_LO =
        {{(ACC_W-NEW_FEATURE_WIDTH+1){1'b1}}, {(NEW_FEATURE_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                                state_q, state_d;
    logic                                  run_q, run_d;
    logic [MAX_NODES*ALPHA_DATA_WIDTH-1:0] alpha_q, alpha_d;
    logic [NUM_NODE_WIDTH-1:0]             n_q, n_d;
    logic [NUM_NODE_WIDTH-1:0]             k_q, k_d;
    logic [SG_W-1:0]                       sg_q, sg_d;
    logic signed [ACC_W-1:0]               acc_q [NUM_FEATURE_OUT];
    logic signed [ACC_W-1:0]               acc_d [NUM_FEATURE_OUT];
    logic [NUM_NODE_WIDTH-1:0]             n_clamp;

    // run_q keeps alpha_rdy low while reset is held, even though IDLE is the reset state
    assign alpha_rdy    = run_q && (state_q == IDLE);
    assign wh_rdy       = (state_q == ACC);
    assign new_feat_vld = (state_q == OUT);
    assign aggr_done    = (state_q == DONE);
    assign n_clamp      = (num_nodes > MAX_N) ? MAX_N : num_nodes;

    always_comb begin
        state_d = state_q;
        run_d   = 1'b1;
        alpha_d = alpha_q;
        n_d     = n_q;
        k_d     = k_q;
        sg_d    = sg_q;
        for (int f = 0; f < NUM_FEATURE_OUT; f++) begin
            acc_d[f] = acc_q[f];
        end

        case (state_q)
            IDLE: begin
                if (alpha_vld && alpha_rdy) begin
                    alpha_d = alpha;
                    n_d     = n_clamp;
                    k_d     = '0;
                    for (int f = 0; f < NUM_FEATURE_OUT; f++) begin
                        acc_d[f] = '0;
                    end
                    state_d = (n_clamp == '0) ? OUT : ACC;
                end
            end
            ACC: begin
                if (wh_vld) begin
                    // alpha is consumed as a shift register so node k is always in the low slot
                    for (int f = 0; f < NUM_FEATURE_OUT; f++) begin
                        acc_d[f] = acc_q[f]
                            + ACC_W'($signed(wh[f*WH_DATA_WIDTH +: WH_DATA_WIDTH]))
                            * ACC_W'($signed({1'b0, alpha_q[ALPHA_DATA_WIDTH-1:0]}));
                    end
                    alpha_d = alpha_q >> ALPHA_DATA_WIDTH;
                    k_d     = k_q + 1'b1;
                    if (k_q == n_q - 1'b1) begin
                        state_d = OUT;
                    end
                end
            end
            OUT: begin
                if (new_feat_rdy) begin
                    sg_d    = sg_q + 1'b1;
                    state_d = (sg_q == SG_W'(NUM_SUBGRAPHS - 1)) ? DONE : IDLE;
                end
            end
            default: begin
                state_d = DONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            run_q   <= 1'b0;
            alpha_q <= '0;
            n_q     <= '0;
            k_q     <= '0;
            sg_q    <= '0;
            for (int f = 0; f < NUM_FEATURE_OUT; f++) begin
                acc_q[f] <= '0;
            end
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            alpha_q <= alpha_d;
            n_q     <= n_d;
            k_q     <= k_d;
            sg_q    <= sg_d;
            for (int f = 0; f < NUM_FEATURE_OUT; f++) begin
                acc_q[f] <= acc_d[f];
            end
        end
    end

    // Accumulators are frozen outside ACC, so the output is stable throughout OUT
    for (genvar f = 0; f < NUM_FEATURE_OUT; f++) begin : g_feat
        logic signed [ACC_W-1:0] shifted;
        assign shifted = acc_q[f] >>> OUT_SHIFT;
        assign new_feat[f*NEW_FEATURE_WIDTH +: NEW_FEATURE_WIDTH] =
            (shifted > SAT_HI) ? SAT_HI[NEW_FEATURE_WIDTH-1:0] :
            (shifted < SAT_LO) ? SAT_LO[NEW_FEATURE_WIDTH-1:0] :
                                 shifted[NEW_FEATURE_WIDTH-1:0];
    end

endmodule
`default_nettype wire

// File: tb/tb_aggregator_mac.sv
`default_nettype none
// =============================================================================
// tb_aggregator_mac : two instances (OUT_SHIFT 16 and 0) driven in lockstep and
//                     compared against an arithmetic reference model.
// Revision          : 1.0
// =============================================================================
module tb_aggregator_mac;

    localparam int WHW  = 12;
    localparam int AW   = 32;
    localparam int NFW  = 32;
    localparam int NF   = 16;
    localparam int MAXN = 12;
    localparam int NSG  = 3;
    localparam int NNW  = $clog2(MAXN);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [MAXN*AW-1:0] alpha;
    logic [NNW-1:0]     num_nodes;
    logic               alpha_vld;
    logic [NF*WHW-1:0]  wh;
    logic               wh_vld;
    logic               new_feat_rdy;

    logic               alpha_rdy_a, wh_rdy_a, vld_a, done_a;
    logic               alpha_rdy_b, wh_rdy_b, vld_b, done_b;
    logic [NF*NFW-1:0]  feat_a, feat_b;

    aggregator_mac #(
        .WH_DATA_WIDTH(WHW), .ALPHA_DATA_WIDTH(AW), .NEW_FEATURE_WIDTH(NFW),
        .NUM_FEATURE_OUT(NF), .MAX_NODES(MAXN), .NUM_SUBGRAPHS(NSG), .OUT_SHIFT(16)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .alpha(alpha), .num_nodes(num_nodes),
        .alpha_vld(alpha_vld), .alpha_rdy(alpha_rdy_a), .wh(wh), .wh_vld(wh_vld),
        .wh_rdy(wh_rdy_a), .new_feat(feat_a), .new_feat_vld(vld_a),
        .new_feat_rdy(new_feat_rdy), .aggr_done(done_a)
    );

    aggregator_mac #(
        .WH_DATA_WIDTH(WHW), .ALPHA_DATA_WIDTH(AW), .NEW_FEATURE_WIDTH(NFW),
        .NUM_FEATURE_OUT(NF), .MAX_NODES(MAXN), .NUM_SUBGRAPHS(NSG), .OUT_SHIFT(0)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .alpha(alpha), .num_nodes(num_nodes),
        .alpha_vld(alpha_vld), .alpha_rdy(alpha_rdy_b), .wh(wh), .wh_vld(wh_vld),
        .wh_rdy(wh_rdy_b), .new_feat(feat_b), .new_feat_vld(vld_b),
        .new_feat_rdy(new_feat_rdy), .aggr_done(done_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] a_tab [MAXN];
    int          w_tab [MAXN][NF];

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: exact sum of products, floor shift, clamp to 32-bit signed
    function automatic logic [511:0] model(input int n, input int sh);
        logic [511:0] r;
        longint acc;
        longint s;
        r = '0;
        for (int f = 0; f < NF; f++) begin
            acc = 0;
            for (int k = 0; k < n; k++) begin
                acc += longint'(w_tab[k][f]) * longint'(a_tab[k]);
            end
            s = acc >>> sh;
            if (s > 64'sd2147483647) s = 64'sd2147483647;
            else if (s < -64'sd2147483648) s = -64'sd2147483648;
            r[f*NFW +: NFW] = s[31:0];
        end
        return r;
    endfunction

    function automatic logic [MAXN*AW-1:0] alpha_bus();
        logic [MAXN*AW-1:0] r;
        for (int k = 0; k < MAXN; k++) r[k*AW +: AW] = a_tab[k];
        return r;
    endfunction

    function automatic logic [NF*WHW-1:0] wh_bus(input int k);
        logic [NF*WHW-1:0] r;
        for (int f = 0; f < NF; f++) r[f*WHW +: WHW] = WHW'(w_tab[k][f]);
        return r;
    endfunction

    function automatic logic [NF*WHW-1:0] junk_wh();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic fill_const(input logic [31:0] a, input int w);
        for (int k = 0; k < MAXN; k++) begin
            a_tab[k] = a;
            for (int f = 0; f < NF; f++) w_tab[k][f] = w;
        end
    endtask

    task automatic fill_rand();
        for (int k = 0; k < MAXN; k++) begin
            case ($urandom_range(9))
                0:       a_tab[k] = 32'hFFFF_FFFF;
                1:       a_tab[k] = 32'h0;
                default: a_tab[k] = $urandom();
            endcase
            for (int f = 0; f < NF; f++) begin
                case ($urandom_range(9))
                    0:       w_tab[k][f] = -2048;
                    1:       w_tab[k][f] = 2047;
                    default: w_tab[k][f] = int'($urandom_range(4095)) - 2048;
                endcase
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        alpha_vld = 1'b0;
        wh_vld = 1'b0;
        new_feat_rdy = 1'b0;
        #1;
        check_eq("rst_alpha_rdy", alpha_rdy_a | alpha_rdy_b, 0);
        check_eq("rst_wh_rdy", wh_rdy_a | wh_rdy_b, 0);
        check_eq("rst_vld", vld_a | vld_b, 0);
        check_eq("rst_done", done_a | done_b, 0);
        check_eq("rst_feat_a", feat_a, 0);
        check_eq("rst_feat_b", feat_b, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_alpha_rdy_a", alpha_rdy_a, 1);
        check_eq("post_rst_alpha_rdy_b", alpha_rdy_b, 1);
    endtask

    task automatic run_sg(input int raw_n, input int gap_pct, input int stall, input bit last);
        int n;
        int k;
        logic [511:0] ea;
        logic [511:0] eb;
        n  = (raw_n > MAXN) ? MAXN : raw_n;
        ea = model(n, 16);
        eb = model(n, 0);
        @(negedge clk);
        check_eq("idle_alpha_rdy_a", alpha_rdy_a, 1);
        check_eq("idle_alpha_rdy_b", alpha_rdy_b, 1);
        check_eq("idle_vld", vld_a | vld_b, 0);
        alpha_vld = 1'b1;
        num_nodes = NNW'(raw_n);
        alpha     = alpha_bus();
        wh_vld    = 1'($urandom_range(1));
        wh        = junk_wh();
        @(negedge clk);
        alpha_vld = 1'b0;
        alpha     = ~alpha;
        num_nodes = NNW'($urandom());
        k = 0;
        while (k < n) begin
            check_eq("acc_wh_rdy_a", wh_rdy_a, 1);
            check_eq("acc_wh_rdy_b", wh_rdy_b, 1);
            check_eq("acc_vld", vld_a | vld_b, 0);
            check_eq("acc_alpha_rdy", alpha_rdy_a | alpha_rdy_b, 0);
            if (int'($urandom_range(99)) < gap_pct) begin
                wh_vld = 1'b0;
                wh     = junk_wh();
            end else begin
                wh_vld = 1'b1;
                wh     = wh_bus(k);
                k++;
            end
            @(negedge clk);
        end
        wh_vld = 1'($urandom_range(1));
        wh     = junk_wh();
        for (int s = 0; s < stall; s++) begin
            check_eq("hold_vld_a", vld_a, 1);
            check_eq("hold_vld_b", vld_b, 1);
            check_eq("hold_feat_a", feat_a, ea);
            check_eq("hold_feat_b", feat_b, eb);
            check_eq("hold_alpha_rdy", alpha_rdy_a | alpha_rdy_b, 0);
            check_eq("hold_wh_rdy", wh_rdy_a | wh_rdy_b, 0);
            new_feat_rdy = 1'b0;
            alpha_vld    = 1'($urandom_range(1));
            wh_vld       = 1'($urandom_range(1));
            @(negedge clk);
        end
        check_eq("out_vld_a", vld_a, 1);
        check_eq("out_vld_b", vld_b, 1);
        check_eq("out_feat_a", feat_a, ea);
        check_eq("out_feat_b", feat_b, eb);
        alpha_vld    = 1'b0;
        new_feat_rdy = 1'b1;
        @(negedge clk);
        new_feat_rdy = 1'b0;
        wh_vld       = 1'b0;
        check_eq("post_vld", vld_a | vld_b, 0);
        check_eq("post_done_a", done_a, last);
        check_eq("post_done_b", done_b, last);
        check_eq("post_alpha_rdy_a", alpha_rdy_a, !last);
    endtask

    task automatic done_checks();
        for (int i = 0; i < 3; i++) begin
            alpha_vld    = 1'b1;
            wh_vld       = 1'b1;
            new_feat_rdy = 1'b1;
            @(negedge clk);
            check_eq("done_alpha_rdy", alpha_rdy_a | alpha_rdy_b, 0);
            check_eq("done_wh_rdy", wh_rdy_a | wh_rdy_b, 0);
            check_eq("done_vld", vld_a | vld_b, 0);
            check_eq("done_flag", done_a & done_b, 1);
        end
        alpha_vld    = 1'b0;
        wh_vld       = 1'b0;
        new_feat_rdy = 1'b0;
    endtask

    task automatic mid_acc_reset();
        fill_rand();
        @(negedge clk);
        alpha_vld = 1'b1;
        num_nodes = NNW'(3);
        alpha     = alpha_bus();
        @(negedge clk);
        alpha_vld = 1'b0;
        wh_vld    = 1'b1;
        wh        = wh_bus(0);
        @(negedge clk);
        wh = wh_bus(1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_alpha_rdy", alpha_rdy_a | alpha_rdy_b, 0);
        check_eq("midrst_wh_rdy", wh_rdy_a | wh_rdy_b, 0);
        check_eq("midrst_vld", vld_a | vld_b, 0);
        check_eq("midrst_feat_a", feat_a, 0);
        check_eq("midrst_feat_b", feat_b, 0);
        wh_vld = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_sg(3, 20, 1, 1'b0);
    endtask

    initial begin
        alpha        = '0;
        num_nodes    = '0;
        alpha_vld    = 1'b0;
        wh           = '0;
        wh_vld       = 1'b0;
        new_feat_rdy = 1'b0;
        do_reset();

        fill_const(32'h4000_0000, 100);
        run_sg(2, 0, 2, 1'b0);
        fill_const(32'h8000_0000, -8);
        run_sg(1, 0, 0, 1'b0);
        run_sg(0, 0, 5, 1'b1);
        done_checks();

        do_reset();
        fill_const(32'h8000_0000, 2047);
        run_sg(1, 0, 1, 1'b0);
        fill_const(32'h8000_0000, -2048);
        run_sg(1, 0, 1, 1'b0);

        do_reset();
        mid_acc_reset();

        for (int it = 0; it < 15; it++) begin
            do_reset();
            for (int s = 0; s < NSG; s++) begin
                fill_rand();
                run_sg(int'($urandom_range(15)), 30, int'($urandom_range(3)), s == NSG - 1);
            end
            done_checks();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
